// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared constants and types for the round-robin 4:1 mux
package rr_mux_pkg;

    localparam int NUM_CH        = 4;
    localparam int IDX_W         = 2;
    localparam int DEFAULT_WIDTH = 4;

    typedef logic [IDX_W-1:0]  ch_idx_t;
    typedef logic [NUM_CH-1:0] ch_mask_t;

endpackage

// File: rtl/rr_mux_4_1_arb_if.sv
// rtl/rr_mux_4_1_arb_if.sv - channel inputs and output beat bundle for the 4:1 mux
interface rr_mux_4_1_arb_if
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    ch_mask_t         in_valid;
    ch_mask_t         in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    ch_idx_t          out_src;

    // Producers and the downstream consumer
    modport master (
        output d0, d1, d2, d3, in_valid, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    // The mux itself
    modport slave (
        input  d0, d1, d2, d3, in_valid, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-way round-robin arbiter owning the search pointer
module rr_arbiter_4
    import rr_mux_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  ch_mask_t in_valid_i,
    input  logic     load_en_i,
    output ch_mask_t grant_o,
    output ch_idx_t  grant_idx_o,
    output logic     grant_any_o
);

    ch_idx_t  ptr_q;
    ch_idx_t  ptr_d;
    ch_mask_t grant_d;
    ch_idx_t  idx_d;
    logic     found_d;
    ch_idx_t  cand;

    // Search from ptr upward (wrapping) for the first valid channel; a grant is
    // only issued when the output register can take a beat and not in reset.
    always_comb begin
        grant_d = '0;
        idx_d   = '0;
        found_d = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = ptr_q + ch_idx_t'(k);
            if (!found_d && in_valid_i[cand]) begin
                found_d = 1'b1;
                idx_d   = cand;
            end
        end
        if (found_d && load_en_i && !rst) begin
            grant_d[idx_d] = 1'b1;
        end
    end

    // Pointer moves just past the winner on a transfer, otherwise holds
    always_comb begin
        ptr_d = ptr_q;
        if (found_d && load_en_i) begin
            ptr_d = idx_d + 2'd1;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_o     = grant_d;
    assign grant_idx_o = idx_d;
    assign grant_any_o = |grant_d;

endmodule

// File: rtl/rr_mux_4_1_arb.sv
// rtl/rr_mux_4_1_arb.sv - round-robin 4:1 mux with a registered output beat
module rr_mux_4_1_arb
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_mux_4_1_arb_if.slave       bus
);

    logic             load_en;
    ch_mask_t         grant;
    ch_idx_t          grant_idx;
    logic             grant_any;
    logic [WIDTH-1:0] sel_data;

    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    ch_idx_t          out_src_q;
    ch_idx_t          out_src_d;

    // The output slot is free when empty or draining this cycle
    assign load_en = ~out_valid_q | bus.out_ready;

    rr_arbiter_4 u_arb (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.in_valid),
        .load_en_i   (load_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    // AND-OR select on the one-hot grant; ungranted channels are masked to
    // zero so their contents (even unknown) never reach the output.
    assign sel_data = ({WIDTH{grant[0]}} & bus.d0)
                    | ({WIDTH{grant[1]}} & bus.d1)
                    | ({WIDTH{grant[2]}} & bus.d2)
                    | ({WIDTH{grant[3]}} & bus.d3);

    // Next output beat: load on a grant, empty on drain with nothing pending
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load_en) begin
            out_valid_d = grant_any;
            if (grant_any) begin
                out_data_d = sel_data;
                out_src_d  = grant_idx;
            end
        end
    end

    // Output beat register; reset drops any held beat
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.in_ready  = grant;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_4_1_arb.sv
// tb/tb_rr_mux_4_1_arb.sv - self-checking bench for the round-robin 4:1 mux
module tb_rr_mux_4_1_arb;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_mux_4_1_arb_if #(.WIDTH(W)) bus ();

    rr_mux_4_1_arb #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_ptr;
    bit         m_ov;
    logic [W-1:0] m_od;
    int         m_os;
    logic [3:0] ready_pre;

    typedef struct {
        bit         rst;
        logic [3:0] iv;
        bit         ordy;
        logic [3:0] exp_ready;
        bit         exp_ov;
        logic [3:0] exp_od;
        int         exp_os;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] chan_data(input int g);
        case (g)
            0: return bus.d0;
            1: return bus.d1;
            2: return bus.d2;
            default: return bus.d3;
        endcase
    endfunction

    function automatic int model_pick();
        for (int k = 0; k < 4; k++) begin
            if (bus.in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int g;
        g = model_pick();
        if (rst || !(!m_ov || bus.out_ready) || g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    task automatic model_edge();
        int g;
        if (rst) begin
            m_ptr = 0; m_ov = 0; m_od = '0; m_os = 0;
        end else if (!m_ov || bus.out_ready) begin
            g = model_pick();
            if (g >= 0) begin
                m_ov = 1; m_od = chan_data(g); m_os = g; m_ptr = (g + 1) % 4;
            end else begin
                m_ov = 0;
            end
        end
    endtask

    // One clock: check in_ready mid-cycle, then registered outputs after the edge
    task automatic step();
        @(negedge clk);
        ready_pre = bus.in_ready;
        chk("in_ready", ready_pre, model_ready());
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", bus.out_valid, m_ov);
        chk("out_data", bus.out_data, m_od);
        chk("out_src", bus.out_src, m_os);
    endtask

    task automatic drive(input bit r, input logic [3:0] iv, input bit ordy);
        rst = r; bus.in_valid = iv; bus.out_ready = ordy;
    endtask

    initial begin
        m_ptr = 0; m_ov = 0; m_od = '0; m_os = 0;
        bus.d0 = 4'h5; bus.d1 = 4'h6; bus.d2 = 4'h7; bus.d3 = 4'h8;
        drive(1, 4'b0000, 1);

        vecs[0]  = '{1, 4'b1111, 1, 4'b0000, 0, 4'h0, 0};
        vecs[1]  = '{0, 4'b1111, 1, 4'b0001, 1, 4'h5, 0};
        vecs[2]  = '{0, 4'b1111, 1, 4'b0010, 1, 4'h6, 1};
        vecs[3]  = '{0, 4'b1111, 1, 4'b0100, 1, 4'h7, 2};
        vecs[4]  = '{0, 4'b1111, 1, 4'b1000, 1, 4'h8, 3};
        vecs[5]  = '{0, 4'b1111, 1, 4'b0001, 1, 4'h5, 0};
        vecs[6]  = '{1, 4'b1010, 1, 4'b0000, 0, 4'h0, 0};
        vecs[7]  = '{0, 4'b1010, 1, 4'b0010, 1, 4'h6, 1};
        vecs[8]  = '{0, 4'b1010, 1, 4'b1000, 1, 4'h8, 3};
        vecs[9]  = '{0, 4'b1010, 1, 4'b0010, 1, 4'h6, 1};
        vecs[10] = '{0, 4'b1010, 1, 4'b1000, 1, 4'h8, 3};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].ordy);
            step();
            chk($sformatf("vec%0d_ready", i), ready_pre, vecs[i].exp_ready);
            chk($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].exp_ov);
            chk($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp_od);
            chk($sformatf("vec%0d_src", i), bus.out_src, vecs[i].exp_os);
        end

        // Stall holds beat 7 from channel 0, then reload on release
        drive(1, 4'b0000, 1); step();
        bus.d0 = 4'h7; drive(0, 4'b0001, 1); step();
        bus.d0 = 4'h9; bus.d1 = 4'h3;
        drive(0, 4'b1111, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ready", ready_pre, 4'b0000);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, 4'h7);
            chk("stall_src", bus.out_src, 0);
        end
        drive(0, 4'b1111, 1); step();
        chk("release_ready", ready_pre, 4'b0010);
        chk("release_data", bus.out_data, 4'h3);
        chk("release_src", bus.out_src, 1);

        // Pointer wrap: last grant 2, only channel 0 valid
        drive(1, 4'b0000, 1); step();
        drive(0, 4'b0100, 1); step();
        drive(0, 4'b0001, 1); step();
        chk("wrap_ready", ready_pre, 4'b0001);
        chk("wrap_src", bus.out_src, 0);
        drive(0, 4'b1111, 1); step();
        chk("wrap_ptr1", ready_pre, 4'b0010);

        // Reset during a stall discards the beat
        bus.d0 = 4'h7;
        drive(1, 4'b0000, 1); step();
        drive(0, 4'b0001, 1); step();
        drive(0, 4'b1111, 0); step();
        drive(1, 4'b1111, 0); step();
        chk("rst_ready", ready_pre, 4'b0000);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 4'h0);
        chk("rst_src", bus.out_src, 0);
        drive(0, 4'b1111, 1); step();
        chk("post_rst_grant", ready_pre, 4'b0001);
        chk("post_rst_data", bus.out_data, 4'h7);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            bus.d0 = 4'($urandom); bus.d1 = 4'($urandom);
            bus.d2 = 4'($urandom); bus.d3 = 4'($urandom);
            drive(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));
            step();
        end

        // Unknown data on channel 3, which is never offered
        for (int i = 0; i < 100; i++) begin
            bus.d0 = 4'($urandom); bus.d1 = 4'($urandom); bus.d2 = 4'($urandom);
            bus.d3 = 'x;
            drive(0, 4'($urandom) & 4'b0111, ($urandom_range(0, 3) != 0));
            step();
            chk("x_ch3_ready", ready_pre[3], 1'b0);
            n_tests++;
            if ($isunknown(bus.out_data)) begin
                n_fail++;
                $display("FAIL x_out_data: got %0h expected known value", bus.out_data);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
